// File: rtl/seg_scan_if.sv
// Bundle of the display-side signals of the segment scan controller.
// The master side is the datapath that supplies values. The slave side is the scan controller.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [3:0]                bcd_out;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      dp_out;
    logic                      frame_done;
    logic                      load_ack;

    modport master (
        output enable, load, value, dp_in,
        input  bcd_out, digit_en, dp_out, frame_done, load_ack
    );

    modport slave (
        input  enable, load, value, dp_in,
        output bcd_out, digit_en, dp_out, frame_done, load_ack
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// One shared BCD decoder is fed one digit at a time.
// New values are taken only at frame boundaries, so a frame never shows a mix of old and new digits.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | display off, all outputs blank, waiting for enable
// SHOW  | current digit driven for TICK_DIV cycles
// GUARD | all digits off for GUARD_CYC cycles between digits (anti-ghosting)
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int GUARD_CYC  = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(TICK_DIV + GUARD_CYC + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);
    // The guard compare value is unreachable when GUARD_CYC is 0, but it must still be a legal constant.
    localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD_CYC > 0) ? CNT_W'(GUARD_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_next;
    logic                boundary;

    logic [VAL_W-1:0]      disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_q, pend_d;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  digit_on;

    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q;
    logic                  load_ack_q;

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Scan sequencing: next state, dwell counter and digit index, plus frame-boundary detection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SHOW;
                    cnt_d    = '0;
                    idx_d    = '0;
                    boundary = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (GUARD_CYC > 0) begin
                            state_d = GUARD;
                        end else begin
                            idx_d    = idx_next;
                            boundary = (idx_q == IDX_LAST);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d  = SHOW;
                        cnt_d    = '0;
                        idx_d    = idx_next;
                        boundary = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Double buffering: a load always lands in the pending buffer, and the pending buffer moves to the display only at a boundary.
    // A load coinciding with a boundary is therefore queued for the following frame.
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (boundary && pend_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
        end
        pend_val_d = bus.load ? bus.value : pend_val_q;
        pend_dp_d  = bus.load ? bus.dp_in : pend_dp_q;
        pend_d     = bus.load | (pend_q & ~boundary);
    end

    // Leading-zero mask: digit k is blanked when it and every digit above it are zero.
    always_comb begin : lz_calc
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            all_zero   = all_zero & (disp_val_d[4*k +: 4] == 4'h0);
            lz_mask[k] = (LZ_BLANK != 0) && all_zero;
        end
    end

    // Output decode from next-state values so registered outputs line up with the state they describe.
    always_comb begin
        digit_on   = (state_d == SHOW) && !lz_mask[idx_d];
        digit_en_d = '0;
        bcd_d      = 4'hF;
        dp_d       = 1'b0;
        if (digit_on) begin
            digit_en_d = NUM_DIGITS'(1) << idx_d;
            bcd_d      = disp_val_d[4*idx_d +: 4];
            dp_d       = disp_dp_d[idx_d];
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            digit_en_q   <= '0;
            bcd_q        <= 4'hF;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            digit_en_q   <= digit_en_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            frame_done_q <= boundary;
            load_ack_q   <= boundary & pend_q;
        end
    end

    assign bus.digit_en   = digit_en_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.load_ack   = load_ack_q;

endmodule
